switch_debounce: RTL and testbench

- Front-end stage for the 24 board DIP switches.
- Synchronizes each raw pad input into the clk domain and debounces it per bit.
- Drives the clean 24-bit vector that the switch read peripheral returns on CPU loads.
- Also provides a per-bit change-tracking mask and a one-cycle change pulse for software polling.

---
 rtl/switch_debounce_pkg.sv | 17 +
 rtl/switch_debounce_bit.sv | 53 +++++
 rtl/switch_debounce.sv | 66 ++++++
 tb/tb_switch_debounce.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the DIP-switch debounce front end.
// SWITCH_DEBOUNCE_IRQ_EN (optional) enables the sw_irq change interrupt in switch_debounce.
package switch_debounce_pkg;

  localparam int N_SW                = 24;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  typedef logic [N_SW-1:0] sw_vec_t;

  // Counter must hold 0..n, and a zero-width vector is not allowed
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-flop synchronizer, stability counter and debounced flop.
// o_flip is high in the cycle before the edge on which o_db changes.
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_db,
  output logic o_flip
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  logic          w_diff;
  logic          w_flip;

  assign w_diff = (r_sync2 != r_db);
  assign w_flip = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any agreement with the debounced value restarts qualification
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_db   = r_db;
  assign o_flip = w_flip;

endmodule

// File: rtl/switch_debounce.sv
// Debounced DIP-switch vector with change pulse and sticky change mask.
// Optional macro SWITCH_DEBOUNCE_IRQ_EN: sw_irq follows (changed_mask != 0); otherwise tied low.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  input  logic            clr_changed,
  output logic [N_SW-1:0] sw_db,
  output logic            sw_change,
  output logic [N_SW-1:0] changed_mask,
  output logic            sw_irq
);

  sw_vec_t w_db;
  sw_vec_t w_flip;
  logic    r_change;
  sw_vec_t r_mask;

  for (genvar g = 0; g < N_SW; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_raw  (sw_raw[g]),
      .o_db   (w_db[g]),
      .o_flip (w_flip[g])
    );
  end

  // A clear and a flip on the same edge keep only the flipping bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_change <= 1'b0;
      r_mask   <= '0;
    end else begin
      r_change <= |w_flip;
      r_mask   <= clr_changed ? w_flip : (r_mask | w_flip);
    end
  end

`ifdef SWITCH_DEBOUNCE_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |r_mask;
    end
  end

  assign sw_irq = r_irq;
`else
  assign sw_irq = 1'b0;
`endif

  assign sw_db        = w_db;
  assign sw_change    = r_change;
  assign changed_mask = r_mask;

endmodule

// File: tb/tb_switch_debounce.sv
// Randomized and directed bench for switch_debounce against a window-based reference model.
// Honours SWITCH_DEBOUNCE_IRQ_EN the same way as the design.
module tb_switch_debounce;

  localparam int N = 24;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw_raw = '0;
  logic         clr_changed = 1'b0;
  logic [N-1:0] sw_db;
  logic         sw_change;
  logic [N-1:0] changed_mask;
  logic         sw_irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: pipeline of raw samples and per-bit recent sync2 history
  logic [N-1:0] m_s1, m_s2, m_db, m_mask;
  logic         m_change, m_irq;
  bit           hist [N][$];

  switch_debounce #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_raw       (sw_raw),
    .clr_changed  (clr_changed),
    .sw_db        (sw_db),
    .sw_change    (sw_change),
    .changed_mask (changed_mask),
    .sw_irq       (sw_irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Debounced bit flips once the last D synchronized samples all disagree with it
  task automatic model_edge(input logic [N-1:0] raw, input logic clr, input logic rs);
    logic [N-1:0] f;
    logic         irq_n;
    bit           all_diff;
    f = '0;
    if (rs) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_mask = '0;
      m_change = 1'b0; m_irq = 1'b0;
      for (int i = 0; i < N; i++) hist[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        hist[i].push_back(m_s2[i]);
        if (hist[i].size() > D) void'(hist[i].pop_front());
        if (hist[i].size() == D) begin
          all_diff = 1'b1;
          foreach (hist[i][k]) if (hist[i][k] == m_db[i]) all_diff = 1'b0;
          if (all_diff) begin
            f[i]    = 1'b1;
            m_db[i] = ~m_db[i];
            hist[i].delete();
          end
        end
      end
`ifdef SWITCH_DEBOUNCE_IRQ_EN
      irq_n = (m_mask != '0);
`else
      irq_n = 1'b0;
`endif
      m_mask   = clr ? f : (m_mask | f);
      m_change = |f;
      m_s2     = m_s1;
      m_s1     = raw;
      m_irq    = irq_n;
    end
  endtask

  // Called just after a negedge: drive, clock, update model, compare at next negedge
  task automatic step(input logic [N-1:0] raw, input logic clr, input logic rs);
    sw_raw      = raw;
    clr_changed = clr;
    rst         = rs;
    @(posedge clk);
    model_edge(raw, clr, rs);
    @(negedge clk);
    check_eq("sw_db", sw_db, m_db);
    check_eq("sw_change", {23'd0, sw_change}, {23'd0, m_change});
    check_eq("changed_mask", changed_mask, m_mask);
    check_eq("sw_irq", {23'd0, sw_irq}, {23'd0, m_irq});
  endtask

  initial begin
    int           n_chg;
    logic [N-1:0] cur;
    int           hold;
    logic         c, r;

    m_s1 = '0; m_s2 = '0; m_db = '0; m_mask = '0; m_change = 1'b0; m_irq = 1'b0;
    @(negedge clk);

    // Reset with all switches on
    repeat (3) step(24'hFFFFFF, 1'b0, 1'b1);
    check_eq("rst_db", sw_db, 24'h0);
    check_eq("rst_mask", changed_mask, 24'h0);
    check_eq("rst_change", {23'd0, sw_change}, 24'h0);
    check_eq("rst_irq", {23'd0, sw_irq}, 24'h0);
    for (int k = 1; k <= 6; k++) begin
      step(24'hFFFFFF, 1'b0, 1'b0);
      if (k == 5) check_eq("rel_db_early", sw_db, 24'h0);
      if (k == 6) check_eq("rel_db_on", sw_db, 24'hFFFFFF);
    end
    step(24'hFFFFFF, 1'b0, 1'b0);
    step(24'hFFFFFF, 1'b1, 1'b0);
    repeat (2) step(24'hFFFFFF, 1'b0, 1'b0);
    repeat (8) step(24'h0, 1'b0, 1'b0);
    step(24'h0, 1'b1, 1'b0);
    repeat (3) step(24'h0, 1'b0, 1'b0);
    check_eq("idle_irq", {23'd0, sw_irq}, 24'h0);

    // Clean step to 5
    n_chg = 0;
    for (int k = 1; k <= 11; k++) begin
      step(24'h000005, 1'b0, 1'b0);
      if (sw_change) n_chg++;
      if (k == 5) check_eq("step_db_early", sw_db, 24'h0);
      if (k == 6) begin
        check_eq("step_db", sw_db, 24'h000005);
        check_eq("step_mask", changed_mask, 24'h000005);
      end
    end
    check_eq("step_pulse_cnt", 24'(n_chg), 24'd1);

    // Glitch on bit 3 for three cycles
    n_chg = 0;
    for (int k = 1; k <= 11; k++) begin
      step((k <= 3) ? 24'h00000D : 24'h000005, 1'b0, 1'b0);
      if (sw_change) n_chg++;
    end
    check_eq("glitch_db", sw_db, 24'h000005);
    check_eq("glitch_mask", changed_mask, 24'h000005);
    check_eq("glitch_pulse_cnt", 24'(n_chg), 24'd0);

    // Clear coincident with bit 7 flipping
    for (int k = 1; k <= 6; k++) step(24'h000085, (k == 6), 1'b0);
    check_eq("sbc_mask", changed_mask, 24'h000080);
    check_eq("sbc_db", sw_db, 24'h000085);
    step(24'h000085, 1'b0, 1'b0);
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    check_eq("irq_set", {23'd0, sw_irq}, 24'h1);
    step(24'h000085, 1'b1, 1'b0);
    check_eq("irq_hold", {23'd0, sw_irq}, 24'h1);
    step(24'h000085, 1'b0, 1'b0);
    check_eq("irq_clr", {23'd0, sw_irq}, 24'h0);
`else
    check_eq("irq_off", {23'd0, sw_irq}, 24'h0);
    step(24'h000085, 1'b1, 1'b0);
    step(24'h000085, 1'b0, 1'b0);
    check_eq("irq_off2", {23'd0, sw_irq}, 24'h0);
`endif

    // Reset in the middle of qualifying bit 0
    repeat (8) step(24'h0, 1'b0, 1'b0);
    repeat (4) step(24'h000001, 1'b0, 1'b0);
    step(24'h000001, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step(24'h000001, 1'b0, 1'b0);
      if (k == 5) check_eq("midrst_early", sw_db, 24'h0);
      if (k == 6) check_eq("midrst_db", sw_db, 24'h000001);
    end

    // Random: held values with occasional glitches, clears and resets
    cur = 24'h0;
    for (int it = 0; it < 600; it++) begin
      case ($urandom_range(0, 3))
        0:       cur = 24'($urandom);
        1:       cur = cur ^ (24'd1 << $urandom_range(0, N - 1));
        default: cur = cur ^ (24'($urandom) & 24'($urandom) & 24'($urandom));
      endcase
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        c = ($urandom_range(0, 7) == 0);
        r = ($urandom_range(0, 199) == 0);
        step(cur, c, r);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
